multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, input, 1 bit; all state changes SHALL occur on its rising edge.
REQ-002 The block SHALL have reset `rst_n`, input, 1 bit; reset SHALL be asynchronous and active-low.
REQ-003 `opcode`, input, 6 bits: instruction [31:26] from the IR, sampled in DECODE only.
REQ-004 `mem_ack`, input, 1 bit: memory completes the current access this cycle.
REQ-005 `mem_req`, output, 1 bit: memory access pending; high in FETCH, MEMREAD and MEMWRITE.
REQ-006 `MemRead`, `MemWrite`, `IorD`, `IRWrite`, `PCWrite`, `PCWriteCond`, outputs, 1 bit each: memory, IR and PC enables.
REQ-007 `RegWrite`, `RegDst`, `MemtoReg`, `ALUSrcA`, outputs, 1 bit each: register-file and mux selects.
REQ-008 `ALUSrcB` and `PCSource`, outputs, 2 bits each: ALU B-operand select and PC source select.
REQ-009 `ALUOp1` and `ALUOp2`, outputs, 1 bit each: drive the ALU control block (00=add, x1=subtract, 10=funct decode).
REQ-010 `illegal_op`, output, 1 bit: sticky, unsupported opcode decoded.
REQ-011 `state`, output, 4 bits: current state, for debug.

Function
REQ-012 The block SHALL implement a Moore FSM with states IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXEC=7, RCOMPLETE=8, BRANCH=9, JUMP=10 and TRAP=11.
REQ-013 IDLE SHALL drive all outputs to 0 and SHALL go to FETCH unconditionally on the next cycle.
REQ-014 FETCH outputs SHALL be: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-015 In FETCH, IRWrite and PCWrite SHALL be 1 only in the cycle where mem_ack=1; the FSM SHALL hold in FETCH while mem_ack=0 and go to DECODE on mem_ack=1.
REQ-016 DECODE outputs SHALL be ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-017 DECODE next state SHALL be: 000000 -> EXEC; 100011 or 101011 -> MEMADDR; 000100 -> BRANCH; 000010 -> JUMP; any other value -> TRAP.
REQ-018 MEMADDR outputs SHALL be ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state SHALL be MEMREAD for lw and MEMWRITE for sw.
REQ-019 The opcode distinguishing lw from sw SHALL be latched in DECODE and not re-sampled.
REQ-020 MEMREAD outputs SHALL be mem_req=1, MemRead=1, IorD=1; the FSM SHALL hold until mem_ack=1, then go to MEMWB.
REQ-021 MEMWB outputs SHALL be RegWrite=1, MemtoReg=1, RegDst=0; next state SHALL be FETCH.
REQ-022 MEMWRITE outputs SHALL be mem_req=1, MemWrite=1, IorD=1; the FSM SHALL hold until mem_ack=1, then go to FETCH.
REQ-023 EXEC outputs SHALL be ALUSrcA=1, ALUSrcB=00, ALUOp1=1, ALUOp2=0; next state SHALL be RCOMPLETE.
REQ-024 RCOMPLETE outputs SHALL be RegWrite=1, RegDst=1, MemtoReg=0; next state SHALL be FETCH.
REQ-025 BRANCH outputs SHALL be ALUSrcA=1, ALUSrcB=00, ALUOp2=1, PCWriteCond=1, PCSource=01; next state SHALL be FETCH.
REQ-026 JUMP outputs SHALL be PCWrite=1, PCSource=10; next state SHALL be FETCH.
REQ-027 TRAP SHALL set illegal_op=1, hold it until reset, drive all other outputs to 0, and remain in TRAP until reset.
REQ-028 mem_ack SHALL be ignored in every state that does not assert mem_req.
REQ-029 A mem_ack that arrives in the first cycle of a memory state SHALL complete that access (zero wait states, 1-cycle minimum).
REQ-030 Any output not explicitly listed for a state SHALL be 0 in that state.
REQ-031 State-to-output latency SHALL be zero (outputs decoded combinationally from the state register); the only Mealy terms SHALL be the gating of IRWrite and PCWrite by mem_ack in FETCH.
REQ-032 Instruction latency in cycles, excluding wait states, SHALL be: lw 5, sw 4, R-type 4, beq 3, j 3.

Reset
REQ-033 While rst_n=0, state SHALL be IDLE, illegal_op SHALL be 0, the latched opcode SHALL be 0, and all outputs SHALL be 0.
REQ-034 Reset asserted mid-access (MEMREAD, MEMWRITE or FETCH waiting) SHALL abort the access immediately, dropping mem_req asynchronously.
REQ-035 After rst_n deasserts, the block SHALL spend one cycle in IDLE and then enter FETCH.

Structure
REQ-036 State encodings, the opcode constants (RTYPE, LW, SW, BEQ, J), and the ALUSrcB/PCSource/ALUOp encodings SHALL live in the shared package `ctrl_pkg`.
REQ-037 Opcode classification SHALL be one sub-module, `opcode_decode`: combinational, opcode -> {is_rtype, is_mem, is_lw, is_beq, is_j, is_illegal}.
REQ-038 The output decode SHALL be a single case statement on the state.

Verification
REQ-039 lw (100011) with mem_ack delayed 2 cycles in FETCH and 1 cycle in MEMREAD -> state trace 1,1,1,2,3,4,4,5,1; RegWrite=1 and MemtoReg=1 exactly in state 5.
REQ-040 R-type (000000) with zero-wait ack -> trace 1,2,7,8,1; ALUOp1=1 and ALUOp2=0 in EXEC; RegDst=1 in RCOMPLETE.
REQ-041 beq then j -> BRANCH has ALUOp2=1, PCWriteCond=1, PCSource=01; JUMP has PCWrite=1, PCSource=10; each returns to FETCH in 1 cycle.
REQ-042 opcode 111111 -> TRAP, illegal_op=1, mem_req stays 0 for 20 cycles; a subsequent reset clears both.
REQ-043 rst_n pulsed low mid-MEMWRITE with mem_ack=0 -> mem_req and MemWrite fall without waiting for clk; the sequence after release is IDLE, then FETCH.
REQ-044 mem_ack=1 held continuously through DECODE, EXEC and RCOMPLETE -> no state skip; IRWrite and PCWrite are pulsed only in the FETCH ack cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle datapath controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEMADDR   = 4'd3,
    ST_MEMREAD   = 4'd4,
    ST_MEMWB     = 4'd5,
    ST_MEMWRITE  = 4'd6,
    ST_EXEC      = 4'd7,
    ST_RCOMPLETE = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_TRAP      = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - combinational opcode classifier
module opcode_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_rtype,
  output logic       is_mem,
  output logic       is_lw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_illegal
);

  always_comb begin
    is_rtype   = (opcode == OP_RTYPE);
    is_lw      = (opcode == OP_LW);
    is_mem     = is_lw || (opcode == OP_SW);
    is_beq     = (opcode == OP_BEQ);
    is_j       = (opcode == OP_J);
    is_illegal = !(is_rtype || is_mem || is_beq || is_j);
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for a multicycle MIPS-style datapath
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       ALUOp1,
  output logic       ALUOp2,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q;
  logic       illegal_q;
  logic [5:0] dec_opcode;
  logic       is_rtype, is_mem, is_lw, is_beq, is_j, is_illegal;
  ctrl_t      ctrl;

  // Live opcode in DECODE; afterwards the latched copy steers lw vs sw.
  assign dec_opcode = (state_q == ST_DECODE) ? opcode : opcode_q;

  opcode_decode u_opcode_decode (
    .opcode     (dec_opcode),
    .is_rtype   (is_rtype),
    .is_mem     (is_mem),
    .is_lw      (is_lw),
    .is_beq     (is_beq),
    .is_j       (is_j),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= opcode;
        if (is_illegal) illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     if (mem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_rtype)    state_d = ST_EXEC;
        else if (is_mem) state_d = ST_MEMADDR;
        else if (is_beq) state_d = ST_BRANCH;
        else if (is_j)   state_d = ST_JUMP;
        else             state_d = ST_TRAP;
      end
      ST_MEMADDR:   state_d = is_lw ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:   if (mem_ack) state_d = ST_MEMWB;
      ST_MEMWB:     state_d = ST_FETCH;
      ST_MEMWRITE:  if (mem_ack) state_d = ST_FETCH;
      ST_EXEC:      state_d = ST_RCOMPLETE;
      ST_RCOMPLETE: state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_IDLE;
    endcase
  end

  // IRWrite/PCWrite in FETCH are the only terms that look at mem_ack.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ack;
        ctrl.pc_write  = mem_ack;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_BROFF;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMREAD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_RCOMPLETE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

  assign mem_req     = ctrl.mem_req;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IorD        = ctrl.iord;
  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp1      = ctrl.alu_op[1];
  assign ALUOp2      = ctrl.alu_op[0];
  assign illegal_op  = illegal_q;
  assign state       = state_q;

endmodule
